cs_window_param: RTL and testbench



---
 rtl/cs_pkg.sv | 29 ++
 rtl/cs_select.sv | 63 ++++++
 rtl/cs_window_param.sv | 167 ++++++++++++++++
 tb/tb_cs_window_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared defaults, derived widths, FSM state and mode encoding for the
// sliding-window comparator/selector (cs_window_param).
package cs_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_WIN    = 9;
    localparam int DEF_SHIFT  = 3;
    localparam int DEF_OUT_W  = 10;

    function automatic int sum_width(input int data_w, input int win);
        return data_w + $clog2(win + 1);
    endfunction

    function automatic int full_width(input int data_w, input int win);
        return data_w + $clog2(2 * win) + 1;
    endfunction

    localparam int SUM_W  = sum_width(DEF_DATA_W, DEF_WIN);
    localparam int FULL_W = full_width(DEF_DATA_W, DEF_WIN);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_BELOW = 1'b0;
    localparam logic MODE_ABOVE = 1'b1;

endpackage

// File: rtl/cs_select.sv
// Combinational compare-and-reduce tree: picks the window sample nearest the
// average from below (MODE_BELOW) or above (MODE_ABOVE) without dividing.
module cs_select
    import cs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WIN    = DEF_WIN,
    parameter int SUM_W  = sum_width(DEF_DATA_W, DEF_WIN)
) (
    input  logic [DATA_W-1:0] i_win [WIN],
    input  logic [SUM_W-1:0]  i_sum,
    input  logic              i_mode,
    output logic [DATA_W-1:0] o_xappr
);

    localparam int LOG = $clog2(WIN);
    localparam int NP  = 1 << LOG;

    logic w_above;
    assign w_above = (i_mode == MODE_ABOVE);

    // A leaf qualifies when X*WIN sits on the requested side of sum; each
    // node then keeps the qualifying value closest to the average.
    for (genvar l = 0; l <= LOG; l++) begin : g_lvl
        localparam int N = NP >> l;
        logic [DATA_W-1:0] w_val [N];
        logic              w_ok  [N];

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < N; j++) begin : g_j
                if (j < WIN) begin : g_real
                    logic [SUM_W-1:0] w_scaled;
                    assign w_scaled = SUM_W'(i_win[j]) * SUM_W'(WIN);
                    assign w_ok[j]  = w_above ? (w_scaled >= i_sum) : (w_scaled <= i_sum);
                    assign w_val[j] = i_win[j];
                end else begin : g_pad
                    assign w_ok[j]  = 1'b0;
                    assign w_val[j] = '0;
                end
            end
        end else begin : g_node
            for (genvar j = 0; j < N; j++) begin : g_j
                logic [DATA_W-1:0] w_l_val;
                logic [DATA_W-1:0] w_r_val;
                logic              w_l_ok;
                logic              w_r_ok;
                logic              w_r_better;
                logic              w_pick_r;
                assign w_l_val    = g_lvl[l-1].w_val[2*j];
                assign w_r_val    = g_lvl[l-1].w_val[2*j+1];
                assign w_l_ok     = g_lvl[l-1].w_ok[2*j];
                assign w_r_ok     = g_lvl[l-1].w_ok[2*j+1];
                assign w_r_better = w_above ? (w_r_val < w_l_val) : (w_r_val > w_l_val);
                assign w_pick_r   = w_r_ok && (!w_l_ok || w_r_better);
                assign w_ok[j]    = w_l_ok | w_r_ok;
                assign w_val[j]   = w_pick_r ? w_r_val : w_l_val;
            end
        end
    end

    assign o_xappr = g_lvl[LOG].w_val[0];

endmodule

// File: rtl/cs_window_param.sv
// Sliding-window comparator/selector: Y = sat((sum + WIN*Xappr) >> SHIFT).
// Define CS_PIPE_EN to add a snapshot register stage before selection.
module cs_window_param
    import cs_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WIN    = DEF_WIN,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] X,
    input  logic              flush,
    input  logic              mode,
    output logic              out_valid,
    output logic [OUT_W-1:0]  Y,
    output logic              win_full,
    output state_t            o_dbg_state
);

    localparam int SUM_W  = sum_width(DATA_W, WIN);
    localparam int FULL_W = full_width(DATA_W, WIN);
    localparam int CNT_W  = $clog2(WIN + 1);

    // Handshake: in_valid has no back-pressure; X is taken on every rising
    // edge where in_valid=1. out_valid is a one-cycle pulse per accepted sample
    // that left the window full; Y holds between pulses.
    logic [DATA_W-1:0] r_win [WIN];
    logic [SUM_W-1:0]  r_sum;
    logic [CNT_W-1:0]  r_cnt;
    state_t            r_state;
    logic              r_pend;
    logic              r_out_valid;
    logic [OUT_W-1:0]  r_y;

    state_t            w_state_nxt;
    logic [SUM_W-1:0]  w_sum_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_pend_nxt;
    logic [DATA_W-1:0] w_oldest;

    // Until the window is full the last slot holds stale data, so it must not be subtracted.
    assign w_oldest = (r_state == RUN) ? r_win[WIN-1] : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = FILL;
            w_sum_nxt   = in_valid ? SUM_W'(X) : '0;
            w_cnt_nxt   = in_valid ? CNT_W'(1) : '0;
        end else if (in_valid) begin
            w_sum_nxt = r_sum + SUM_W'(X) - SUM_W'(w_oldest);
            if (r_cnt != CNT_W'(WIN)) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            if (r_state == FILL && w_cnt_nxt == CNT_W'(WIN)) begin
                w_state_nxt = RUN;
            end
        end
        w_pend_nxt = in_valid && (w_state_nxt == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= FILL;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sum   <= w_sum_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < WIN; i++) begin
                r_win[i] <= '0;
            end
        end else if (in_valid) begin
            r_win[0] <= X;
            for (int i = 1; i < WIN; i++) begin
                r_win[i] <= r_win[i-1];
            end
        end
    end

    logic [DATA_W-1:0] w_sel_win [WIN];
    logic [SUM_W-1:0]  w_sel_sum;
    logic              w_sel_valid;

`ifdef CS_PIPE_EN
    logic [DATA_W-1:0] r_p_win [WIN];
    logic [SUM_W-1:0]  r_p_sum;
    logic              r_p_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_p_valid <= 1'b0;
            r_p_sum   <= '0;
            for (int i = 0; i < WIN; i++) begin
                r_p_win[i] <= '0;
            end
        end else begin
            r_p_valid <= r_pend;
            if (r_pend) begin
                r_p_sum <= r_sum;
                r_p_win <= r_win;
            end
        end
    end

    assign w_sel_win   = r_p_win;
    assign w_sel_sum   = r_p_sum;
    assign w_sel_valid = r_p_valid;
`else
    assign w_sel_win   = r_win;
    assign w_sel_sum   = r_sum;
    assign w_sel_valid = r_pend;
`endif

    logic [DATA_W-1:0] w_xappr;
    logic [FULL_W-1:0] w_full;
    logic [FULL_W-1:0] w_shifted;
    logic              w_sat;
    logic [OUT_W-1:0]  w_y;

    cs_select #(
        .DATA_W (DATA_W),
        .WIN    (WIN),
        .SUM_W  (SUM_W)
    ) u_select (
        .i_win   (w_sel_win),
        .i_sum   (w_sel_sum),
        .i_mode  (mode),
        .o_xappr (w_xappr)
    );

    assign w_full    = FULL_W'(w_sel_sum) + FULL_W'(w_xappr) * FULL_W'(WIN);
    assign w_shifted = w_full >> SHIFT;
    assign w_sat     = |(w_shifted >> OUT_W);
    assign w_y       = w_sat ? '1 : OUT_W'(w_shifted);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
        end else begin
            r_out_valid <= w_sel_valid;
            if (w_sel_valid) begin
                r_y <= w_y;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign Y           = r_y;
    assign win_full    = (r_state == RUN);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cs_window_param.sv
// Bench for cs_window_param: directed steps then random traffic, checked
// against a queue-based window model with a latency delay line.
module tb_cs_window_param;
    import cs_pkg::*;

    localparam int DW    = 8;
    localparam int WIN   = 9;
    localparam int SHIFT = 3;
    localparam int OUT_W = 10;
`ifdef CS_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef logic [WIN*DW-1:0] snap_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [DW-1:0]    X;
    logic             flush;
    logic             mode;
    logic             out_valid;
    logic [OUT_W-1:0] Y;
    logic             win_full;
    state_t           dbg_state;

    int    n_vec = 0;
    int    n_err = 0;
    int    pulses = 0;
    int    mq[$];
    bit    dl_v[$];
    snap_t dl_s[$];
    int    exp_y = 0;
    bit    exp_ov = 0;
    bit    exp_wf = 0;

    always #5 clk = ~clk;

    cs_window_param #(
        .DATA_W (DW),
        .WIN    (WIN),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .X           (X),
        .flush       (flush),
        .mode        (mode),
        .out_valid   (out_valid),
        .Y           (Y),
        .win_full    (win_full),
        .o_dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result straight from the definition: scan for the nearest sample.
    function automatic int ref_y(input snap_t s, input bit m);
        int sum;
        int best;
        int v;
        int y;
        sum  = 0;
        for (int i = 0; i < WIN; i++) sum += int'(s[i*DW +: DW]);
        best = m ? 1 << 30 : -1;
        for (int i = 0; i < WIN; i++) begin
            v = int'(s[i*DW +: DW]);
            if (!m && v * WIN <= sum && v > best) best = v;
            if (m && v * WIN >= sum && v < best) best = v;
        end
        y = (sum + WIN * best) >> SHIFT;
        if (y > (1 << OUT_W) - 1) y = (1 << OUT_W) - 1;
        return y;
    endfunction

    task automatic cycle(input bit rst_n, input bit v, input int x, input bit f, input bit m);
        bit    v0;
        snap_t s0;
        snap_t sn;
        int    t;
        reset    = rst_n;
        in_valid = v;
        X        = x[DW-1:0];
        flush    = f;
        mode     = m;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            dl_v.delete();
            dl_s.delete();
            for (int i = 0; i < LAT; i++) begin
                dl_v.push_back(1'b0);
                dl_s.push_back('0);
            end
            exp_ov = 0;
            exp_y  = 0;
        end else begin
            v0 = dl_v.pop_front();
            s0 = dl_s.pop_front();
            exp_ov = v0;
            if (v0) exp_y = ref_y(s0, m);
            if (f) mq.delete();
            if (v) begin
                mq.push_front(x & ((1 << DW) - 1));
                if (mq.size() > WIN) void'(mq.pop_back());
            end
            sn = '0;
            if (mq.size() == WIN) begin
                for (int i = 0; i < WIN; i++) begin
                    t = mq[i];
                    sn[i*DW +: DW] = t[DW-1:0];
                end
            end
            dl_v.push_back(v && mq.size() == WIN);
            dl_s.push_back(sn);
        end
        exp_wf = (mq.size() == WIN);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        chk("y", {22'b0, Y}, exp_y);
        chk("win_full", {31'b0, win_full}, {31'b0, exp_wf});
        chk("dbg_state", {31'b0, dbg_state == RUN}, {31'b0, exp_wf});
        if (out_valid === 1'b1) pulses++;
    endtask

    task automatic acc(input int x, input bit m);
        cycle(1'b1, 1'b1, x, 1'b0, m);
    endtask

    task automatic idle(input bit m);
        cycle(1'b1, 1'b0, 0, 1'b0, m);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rst_n;
        bit v;
        bit f;
        int x;

        do_reset();
        do_reset();
        chk("reset_y", {22'b0, Y}, 0);
        chk("reset_wf", {31'b0, win_full}, 0);

        // Eight zeros then 0x0A, mode 0
        pulses = 0;
        repeat (8) acc(0, 1'b0);
        acc(8'h0A, 1'b0);
        chk("tp1_wf", {31'b0, win_full}, 1);
        repeat (LAT) idle(1'b0);
        chk("tp1_y", {22'b0, Y}, 1);
        chk("tp1_pulses", pulses, 1);
        idle(1'b0);
        chk("tp1_once", {31'b0, out_valid}, 0);

        // Same window, mode 1
        do_reset();
        pulses = 0;
        repeat (8) acc(0, 1'b1);
        acc(8'h0A, 1'b1);
        repeat (LAT) idle(1'b1);
        chk("tp2_y", {22'b0, Y}, 32'h00C);
        chk("tp2_pulses", pulses, 1);

        // All 0xFF, then slide in a zero
        do_reset();
        repeat (9) acc(8'hFF, 1'b0);
        repeat (LAT) idle(1'b0);
        chk("tp3_y", {22'b0, Y}, 32'h23D);
        acc(8'h00, 1'b0);
        repeat (LAT) idle(1'b0);
        chk("tp3_slide_y", {22'b0, Y}, 32'h0FF);

        // Alternating gaps: one pulse per accept
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, (i % 2) == 0, $urandom_range(0, 255), 1'b0, 1'(($urandom_range(0, 1))));
        end
        repeat (LAT) idle(1'b0);
        chk("gap_pulses", pulses, 10);

        // Flush with a simultaneous sample while in RUN
        idle(1'b0);
        pulses = 0;
        cycle(1'b1, 1'b1, 8'h05, 1'b1, 1'b0);
        chk("flush_wf", {31'b0, win_full}, 0);
        repeat (7) acc(8'h10, 1'b0);
        repeat (LAT) idle(1'b0);
        chk("flush_early", pulses, 0);
        acc(8'h10, 1'b0);
        repeat (LAT) idle(1'b0);
        chk("flush_pulses", pulses, 1);
        chk("flush_y", {22'b0, Y}, 22);

        // Reset in the middle of a stream
        repeat (3) acc($urandom_range(0, 255), 1'b0);
        do_reset();
        chk("mid_rst_y", {22'b0, Y}, 0);
        chk("mid_rst_ov", {31'b0, out_valid}, 0);
        chk("mid_rst_wf", {31'b0, win_full}, 0);
        pulses = 0;
        repeat (8) acc($urandom_range(0, 255), 1'b1);
        repeat (LAT) idle(1'b1);
        chk("rst_early", pulses, 0);
        acc($urandom_range(0, 255), 1'b1);
        repeat (LAT) idle(1'b1);
        chk("rst_pulses", pulses, 1);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            v     = ($urandom_range(0, 9) < 7);
            f     = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       x = 0;
                1:       x = 255;
                default: x = $urandom_range(0, 255);
            endcase
            cycle(rst_n, v, x, f, 1'(($urandom_range(0, 1))));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
